control_penales: RTL and testbench

CONTROL_PENALES -- requirements
Module: control_penales

---
 rtl/control_penales.sv | 130 +++++++++++++
 tb/tb_control_penales.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_penales.sv
// Penalty shoot-out controller: edge-detects the three buttons, alternates shooters,
// keeps goal/shot counters and decides the winner (regulation, sudden death, draw cap).
module control_penales (
   input  logic       clk,
   input  logic       rst,
   input  logic       inicio,
   input  logic       gol,
   input  logic       fallo,
   output logic [3:0] goles1,
   output logic [3:0] goles2,
   output logic [3:0] tiros1,
   output logic [3:0] tiros2,
   output logic       turno,
   output logic       evento,
   output logic       fin,
   output logic [1:0] ganador
);

   typedef enum logic [1:0] {IDLE, TIRO1, TIRO2, FIN} state_t;

   state_t     state_q;
   logic       inicioPrev_q, golPrev_q, falloPrev_q;
   logic [3:0] goles1_q, goles2_q, tiros1_q, tiros2_q;
   logic       turno_q, evento_q, fin_q;
   logic [1:0] ganador_q;

   logic       inicioEv, golEv, falloEv, shotEv, shooterIsP2;
   logic [3:0] goles1_d, goles2_d, tiros1_d, tiros2_d;
   logic [4:0] rem1, rem2;
   logic [1:0] ganador_d;

   // Candidate post-shot counters and the verdict they would produce
   always_comb begin
      inicioEv    = inicio & ~inicioPrev_q;
      golEv       = gol & ~golPrev_q;
      falloEv     = fallo & ~falloPrev_q;
      shotEv      = golEv ^ falloEv;
      shooterIsP2 = (state_q == TIRO2);

      goles1_d = goles1_q + {3'b000, golEv & ~shooterIsP2};
      tiros1_d = tiros1_q + {3'b000, ~shooterIsP2};
      goles2_d = goles2_q + {3'b000, golEv & shooterIsP2};
      tiros2_d = tiros2_q + {3'b000, shooterIsP2};

      rem1 = (tiros1_d >= 4'd5) ? 5'd0 : (5'd5 - {1'b0, tiros1_d});
      rem2 = (tiros2_d >= 4'd5) ? 5'd0 : (5'd5 - {1'b0, tiros2_d});

      ganador_d = 2'b00;
      if ((tiros1_d < 4'd5) || (tiros2_d < 4'd5)) begin
         if ({1'b0, goles1_d} > ({1'b0, goles2_d} + rem2)) begin
            ganador_d = 2'b01;
         end else if ({1'b0, goles2_d} > ({1'b0, goles1_d} + rem1)) begin
            ganador_d = 2'b10;
         end
      end else if (shooterIsP2) begin
         // Sudden death is only judged once both players have shot in the round
         if (goles1_d > goles2_d) begin
            ganador_d = 2'b01;
         end else if (goles2_d > goles1_d) begin
            ganador_d = 2'b10;
         end else if ((tiros1_d == 4'd15) && (tiros2_d == 4'd15)) begin
            ganador_d = 2'b11;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         inicioPrev_q <= 1'b1;
         golPrev_q    <= 1'b1;
         falloPrev_q  <= 1'b1;
         goles1_q     <= 4'd0;
         goles2_q     <= 4'd0;
         tiros1_q     <= 4'd0;
         tiros2_q     <= 4'd0;
         turno_q      <= 1'b0;
         evento_q     <= 1'b0;
         fin_q        <= 1'b0;
         ganador_q    <= 2'b00;
      end else begin
         inicioPrev_q <= inicio;
         golPrev_q    <= gol;
         falloPrev_q  <= fallo;
         evento_q     <= 1'b0;
         case (state_q)
            IDLE, FIN: begin
               if (inicioEv) begin
                  state_q   <= TIRO1;
                  goles1_q  <= 4'd0;
                  goles2_q  <= 4'd0;
                  tiros1_q  <= 4'd0;
                  tiros2_q  <= 4'd0;
                  turno_q   <= 1'b0;
                  fin_q     <= 1'b0;
                  ganador_q <= 2'b00;
               end
            end
            TIRO1, TIRO2: begin
               if (shotEv) begin
                  goles1_q <= goles1_d;
                  goles2_q <= goles2_d;
                  tiros1_q <= tiros1_d;
                  tiros2_q <= tiros2_d;
                  evento_q <= 1'b1;
                  if (ganador_d != 2'b00) begin
                     state_q   <= FIN;
                     fin_q     <= 1'b1;
                     ganador_q <= ganador_d;
                  end else begin
                     state_q <= shooterIsP2 ? TIRO1 : TIRO2;
                     turno_q <= ~shooterIsP2;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign goles1  = goles1_q;
   assign goles2  = goles2_q;
   assign tiros1  = tiros1_q;
   assign tiros2  = tiros2_q;
   assign turno   = turno_q;
   assign evento  = evento_q;
   assign fin     = fin_q;
   assign ganador = ganador_q;

endmodule

// File: tb/tb_control_penales.sv
// Scoreboard bench for control_penales: directed scenarios plus random games, with an
// abstract game model pushing expected scores that a monitor pops on every evento pulse.
module tb_control_penales;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inicio = 1'b0;
   logic       gol = 1'b1;
   logic       fallo = 1'b0;
   logic [3:0] goles1, goles2, tiros1, tiros2;
   logic       turno, evento, fin;
   logic [1:0] ganador;

   typedef struct {
      int g1; int g2; int t1; int t2; int turn; int fin; int win;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   evCount = 0;

   // Abstract game: 0 = waiting, 1 = playing, 2 = over
   int mState = 0;
   int mG1 = 0, mG2 = 0, mT1 = 0, mT2 = 0, mTurn = 0, mFin = 0, mWin = 0;

   control_penales dut (
      .clk(clk), .rst(rst), .inicio(inicio), .gol(gol), .fallo(fallo),
      .goles1(goles1), .goles2(goles2), .tiros1(tiros1), .tiros2(tiros2),
      .turno(turno), .evento(evento), .fin(fin), .ganador(ganador)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      mState = 0; mG1 = 0; mG2 = 0; mT1 = 0; mT2 = 0; mTurn = 0; mFin = 0; mWin = 0;
   endfunction

   function automatic int decide(input int afterJ2);
      int rem1 = (mT1 >= 5) ? 0 : 5 - mT1;
      int rem2 = (mT2 >= 5) ? 0 : 5 - mT2;
      if (mT1 < 5 || mT2 < 5) begin
         if (mG1 > mG2 + rem2) return 1;
         if (mG2 > mG1 + rem1) return 2;
         return 0;
      end
      if (afterJ2 == 0) return 0;
      if (mG1 > mG2) return 1;
      if (mG2 > mG1) return 2;
      if (mT1 == 15 && mT2 == 15) return 3;
      return 0;
   endfunction

   function automatic void modelEdge(input bit i, input bit g, input bit f);
      exp_t e;
      int shooter;
      if (i && mState != 1) begin
         modelReset();
         mState = 1;
      end else if (mState == 1 && (g != f)) begin
         shooter = mTurn;
         if (shooter == 0) begin
            mT1 = mT1 + 1; mG1 = mG1 + (g ? 1 : 0);
         end else begin
            mT2 = mT2 + 1; mG2 = mG2 + (g ? 1 : 0);
         end
         mWin = decide(shooter);
         if (mWin != 0) begin
            mState = 2; mFin = 1;
         end else begin
            mTurn = 1 - shooter;
         end
         e.g1 = mG1; e.g2 = mG2; e.t1 = mT1; e.t2 = mT2;
         e.turn = mTurn; e.fin = mFin; e.win = mWin;
         expQ.push_back(e);
      end
   endfunction

   // Monitor: every evento pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (evento === 1'b1) begin
         evCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpectedEvento: got evento=1 with goles %0d/%0d tiros %0d/%0d, required no pulse",
                     goles1, goles2, tiros1, tiros2);
         end else begin
            e = expQ.pop_front();
            if (goles1 !== 4'(e.g1) || goles2 !== 4'(e.g2) || tiros1 !== 4'(e.t1) ||
                tiros2 !== 4'(e.t2) || fin !== 1'(e.fin) || ganador !== 2'(e.win) ||
                (e.fin == 0 && turno !== 1'(e.turn))) begin
               errors++;
               $display("[TB] FAIL shotRecord: got g=%0d/%0d t=%0d/%0d turno=%0d fin=%0d ganador=%0d, required g=%0d/%0d t=%0d/%0d turno=%0d fin=%0d ganador=%0d",
                        goles1, goles2, tiros1, tiros2, turno, fin, ganador,
                        e.g1, e.g2, e.t1, e.t2, e.turn, e.fin, e.win);
            end
         end
      end
   end

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkField({tag, ".goles1"}, 32'(goles1), mG1);
      checkField({tag, ".goles2"}, 32'(goles2), mG2);
      checkField({tag, ".tiros1"}, 32'(tiros1), mT1);
      checkField({tag, ".tiros2"}, 32'(tiros2), mT2);
      checkField({tag, ".fin"}, 32'(fin), mFin);
      checkField({tag, ".ganador"}, 32'(ganador), mWin);
      checkField({tag, ".evento"}, 32'(evento), 0);
      if (mFin == 0) checkField({tag, ".turno"}, 32'(turno), mTurn);
   endtask

   // Raise the chosen buttons together, hold them, release, then confirm nothing is owed
   task automatic applyStimulus(input bit i, input bit g, input bit f, input int hold);
      @(negedge clk);
      inicio = i; gol = g; fallo = f;
      modelEdge(i, g, f);
      repeat (hold) @(negedge clk);
      inicio = 1'b0; gol = 1'b0; fallo = 1'b0;
      @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL missingEvento: got %0d shots unreported, required 0", expQ.size());
         expQ.delete();
      end
   endtask

   task automatic doReset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      modelReset();
      expQ.delete();
   endtask

   initial begin
      #1000000;
      errors++;
      $display("[TB] FAIL watchdog: got no end of run within time limit, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int evBefore;
      int choice;
      // gol is already high while reset spans two edges, and stays high afterwards
      repeat (2) @(negedge clk);
      rst = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset");
      checkField("reset.noEvento", evCount, 0);
      gol = 1'b0;
      @(negedge clk);

      $display("[TB] early win");
      applyStimulus(1, 0, 0, 1);
      checkOutput("start");
      for (int r = 0; r < 3; r++) begin
         applyStimulus(0, 1, 0, 1);
         applyStimulus(0, 0, 1, 1);
      end
      checkOutput("earlyWin");
      checkField("earlyWin.ganadorConst", 32'(ganador), 1);
      checkField("earlyWin.golesConst", 32'({goles1, goles2}), 32'h30);

      $display("[TB] sudden death");
      applyStimulus(1, 0, 0, 1);
      for (int r = 0; r < 5; r++) begin
         applyStimulus(0, 1, 0, 1);
         applyStimulus(0, 1, 0, 1);
      end
      checkOutput("sd5");
      checkField("sd5.finConst", 32'(fin), 0);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 1, 0, 1);
      checkOutput("sd6");
      checkField("sd6.ganadorConst", 32'(ganador), 2);
      checkField("sd6.tirosConst", 32'({tiros1, tiros2}), 32'h66);

      $display("[TB] input hygiene");
      applyStimulus(1, 0, 0, 1);
      evBefore = evCount;
      applyStimulus(0, 1, 0, 10);
      checkField("holdOnce.pulses", evCount - evBefore, 1);
      checkOutput("holdOnce");
      applyStimulus(0, 1, 1, 2);
      checkOutput("bothPressed");
      applyStimulus(1, 0, 0, 1);
      checkOutput("inicioInPlay");

      $display("[TB] reset mid-game");
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 1, 0, 1);
      checkField("midGame.tiros1", 32'(tiros1), 2);
      doReset(1);
      checkOutput("midReset");
      applyStimulus(0, 1, 0, 1);
      checkOutput("idleGol");
      applyStimulus(0, 0, 1, 2);
      checkOutput("idleFallo");

      $display("[TB] draw cap");
      applyStimulus(1, 0, 0, 1);
      for (int r = 0; r < 15; r++) begin
         applyStimulus(0, 1, 0, 1);
         applyStimulus(0, 1, 0, 1);
      end
      checkOutput("drawCap");
      checkField("drawCap.ganadorConst", 32'(ganador), 3);
      checkField("drawCap.golesConst", 32'({goles1, goles2}), 32'hFF);
      applyStimulus(0, 1, 0, 1);
      checkOutput("finGolIgnored");
      applyStimulus(1, 0, 0, 1);
      checkOutput("restart");
      checkField("restart.tirosConst", 32'({tiros1, tiros2}), 0);

      $display("[TB] random games");
      for (int game = 0; game < 8; game++) begin
         applyStimulus(1, 0, 0, 1);
         for (int step = 0; step < 60 && mState == 1; step++) begin
            choice = $urandom_range(0, 9);
            if (choice == 0) begin
               applyStimulus(0, 1, 1, $urandom_range(1, 2));
            end else if (choice == 1) begin
               applyStimulus(1, 0, 0, 1);
            end else begin
               if ($urandom_range(0, 99) < 70) applyStimulus(0, 1, 0, $urandom_range(1, 3));
               else applyStimulus(0, 0, 1, $urandom_range(1, 3));
            end
         end
         checkOutput("randomGame");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
